// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with a one-word holding buffer
// and a configurable idle gap between frames.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);
    localparam logic [CW-1:0] BLAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAPWAIT} state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic             hold_full;
    logic [CW-1:0]    bcnt;
    logic [GW-1:0]    gcnt;
    logic             last;
    logic             load;

    assign din_ready = !hold_full;
    assign last      = (state == SHIFT) && (bcnt == BLAST);
    // With no gap the next word is chained straight in on the last bit.
    assign load      = hold_full && ((state == IDLE) || (last && GAP == 0));
    assign shifted   = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    assign so_valid  = (state == SHIFT);
    assign so        = so_valid && ((MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0]);
    assign done      = last;
    assign busy      = (state != IDLE) || hold_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            sreg      <= '0;
            bcnt      <= '0;
            gcnt      <= '0;
        end else begin
            if (din_valid && !hold_full) begin
                hold      <= din;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load) begin
                sreg  <= hold;
                bcnt  <= '0;
                state <= SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        if (last) begin
                            state <= (GAP > 0) ? GAPWAIT : IDLE;
                            gcnt  <= '0;
                        end else begin
                            sreg <= shifted;
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                    GAPWAIT: begin
                        if (gcnt == GLAST) state <= IDLE;
                        else gcnt <= gcnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: vector table, directed corner sequences and a randomized
// transaction-level reference model for the default configuration.
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic [2:0] rdy, so, sv, bsy, dn;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy[0]),
        .so(so[0]), .so_valid(sv[0]), .busy(bsy[0]), .done(dn[0]));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy[1]),
        .so(so[1]), .so_valid(sv[1]), .busy(bsy[1]), .done(dn[1]));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy[2]),
        .so(so[2]), .so_valid(sv[2]), .busy(bsy[2]), .done(dn[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic v, input logic [7:0] d);
        rst_n = r;
        din_valid = v;
        din = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model for u0: a frame loads at max(handshake+1, earliest free edge),
    // occupies WIDTH cycles, then GAP wait cycles plus one IDLE cycle before the next load.
    localparam int W = 8;
    localparam int G0 = 1;
    bit         m_pend = 0;
    logic [7:0] m_word = 8'h00;
    int         m_load = 0, m_free = 0, m_busy_end = 0, m_e = 0, m_acc = 0;
    bit         m_so[int];
    bit         m_done[int];
    bit         chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model so_valid", sv[0], m_so.exists(m_e));
            chk("model so", so[0], m_so.exists(m_e) ? m_so[m_e] : 1'b0);
            chk("model done", dn[0], m_done.exists(m_e));
            chk("model din_ready", rdy[0], !m_pend);
            chk("model busy", bsy[0], m_pend || m_e < m_busy_end);
        end
        m_e++;
        if (!rst_n) begin
            m_pend = 0;
            m_free = 0;
            m_busy_end = 0;
            m_so.delete();
            m_done.delete();
        end else if (m_pend && m_e == m_load) begin
            for (int j = 0; j < W; j++) m_so[m_e + j] = m_word[W-1-j];
            m_done[m_e + W - 1] = 1;
            m_free = m_e + W + ((G0 > 0) ? G0 + 1 : 0);
            m_busy_end = m_e + W + G0;
            m_pend = 0;
        end else if (!m_pend && din_valid) begin
            m_pend = 1;
            m_word = din;
            m_load = (m_e + 1 > m_free) ? m_e + 1 : m_free;
            m_acc++;
        end
    end

    typedef struct {
        int sel;
        logic r, v;
        logic [7:0] d;
        logic so, sv, dn, rdy, bsy;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input int sel, input logic r, input logic v, input logic [7:0] d,
                                input logic eso, input logic esv, input logic edn,
                                input logic erdy, input logic ebsy);
        vec_t x;
        x.sel = sel; x.r = r; x.v = v; x.d = d;
        x.so = eso; x.sv = esv; x.dn = edn; x.rdy = erdy; x.bsy = ebsy;
        tbl.push_back(x);
    endfunction

    logic [7:0]  seq_a, seq_b;
    logic [15:0] stream;
    logic        c_so[0:31], c_sv[0:31], c_rdy[0:31];
    int          nd, nv, acc0;

    initial begin
        seq_a = 8'b10100101;
        seq_b = 8'b01111000;
        add(0, 0, 0, 8'h00, 0, 0, 0, 1, 0);
        add(0, 1, 1, 8'hA5, 0, 0, 0, 0, 1);
        for (int j = 0; j < 8; j++) add(0, 1, 0, 8'h00, seq_a[7-j], 1, j == 7, 1, 1);
        add(0, 1, 0, 8'h00, 0, 0, 0, 1, 1);
        add(0, 1, 0, 8'h00, 0, 0, 0, 1, 0);
        add(1, 0, 0, 8'h00, 0, 0, 0, 1, 0);
        add(1, 1, 1, 8'h1E, 0, 0, 0, 0, 1);
        for (int j = 0; j < 8; j++) add(1, 1, 0, 8'h00, seq_b[7-j], 1, j == 7, 1, 1);
        add(1, 1, 0, 8'h00, 0, 0, 0, 1, 1);
        add(1, 1, 0, 8'h00, 0, 0, 0, 1, 0);
        add(2, 0, 0, 8'h00, 0, 0, 0, 1, 0);
        add(2, 1, 1, 8'hFF, 0, 0, 0, 0, 1);
        add(2, 1, 1, 8'h00, 1, 1, 0, 1, 1);
        add(2, 1, 1, 8'h00, 1, 1, 0, 0, 1);
        for (int j = 2; j < 8; j++) add(2, 1, 0, 8'h00, 1, 1, j == 7, 0, 1);
        for (int j = 0; j < 8; j++) add(2, 1, 0, 8'h00, 0, 1, j == 7, 1, 1);
        add(2, 1, 0, 8'h00, 0, 0, 0, 1, 0);

        tick(0, 0, 8'h00);
        chk_en = 1;
        foreach (tbl[i]) begin
            tick(tbl[i].r, tbl[i].v, tbl[i].d);
            chk($sformatf("vec%0d so", i), so[tbl[i].sel], tbl[i].so);
            chk($sformatf("vec%0d so_valid", i), sv[tbl[i].sel], tbl[i].sv);
            chk($sformatf("vec%0d done", i), dn[tbl[i].sel], tbl[i].dn);
            chk($sformatf("vec%0d din_ready", i), rdy[tbl[i].sel], tbl[i].rdy);
            chk($sformatf("vec%0d busy", i), bsy[tbl[i].sel], tbl[i].bsy);
        end

        // Second word offered during the first frame's shift.
        tick(0, 0, 8'h00);
        stream = '0;
        nv = 0;
        for (int t = 1; t <= 22; t++) begin
            tick(1, t == 1 || t == 3, (t == 1) ? 8'hA5 : 8'h3C);
            c_so[t] = so[0];
            c_sv[t] = sv[0];
            c_rdy[t] = rdy[0];
            if (sv[0]) begin
                stream = {stream[14:0], so[0]};
                nv++;
            end
        end
        chk("overlap stream", stream, 16'hA53C);
        chk("overlap valid count", nv, 16);
        chk("overlap ready after 2nd hs", c_rdy[3], 0);
        chk("overlap ready before load", c_rdy[11], 0);
        chk("overlap ready after load", c_rdy[12], 1);
        chk("overlap last A5 bit", c_sv[9], 1);
        chk("overlap gap cycle", c_sv[10], 0);
        chk("overlap idle cycle", c_sv[11], 0);
        chk("overlap 3C start", c_sv[12], 1);
        chk("overlap 3C first bit", c_so[12], 0);

        // Reset on bit 4 with a word held.
        tick(0, 0, 8'h00);
        tick(1, 1, 8'hA5);
        tick(1, 0, 8'h00);
        tick(1, 1, 8'h3C);
        tick(1, 0, 8'h00);
        tick(1, 0, 8'h00);
        chk("pre-reset held", rdy[0], 0);
        chk("pre-reset bit4 valid", sv[0], 1);
        tick(0, 0, 8'h00);
        chk("abort so", so[0], 0);
        chk("abort so_valid", sv[0], 0);
        chk("abort busy", bsy[0], 0);
        chk("abort din_ready", rdy[0], 1);
        chk("abort done", dn[0], 0);
        nd = 0;
        nv = 0;
        for (int t = 0; t < 12; t++) begin
            tick(1, 0, 8'h00);
            nd += int'(dn[0]);
            nv += int'(sv[0]);
        end
        chk("abort no done", nd, 0);
        chk("abort no frame", nv, 0);
        tick(1, 1, 8'h81);
        stream = '0;
        nv = 0;
        nd = 0;
        for (int t = 0; t < 10; t++) begin
            tick(1, 0, 8'h00);
            nd += int'(dn[0]);
            if (sv[0]) begin
                stream = {stream[14:0], so[0]};
                nv++;
            end
        end
        chk("post-reset 81 bits", stream[7:0], 8'h81);
        chk("post-reset 81 count", nv, 8);
        chk("post-reset 81 done", nd, 1);

        // din_valid toggling regardless of din_ready.
        tick(0, 0, 8'h00);
        acc0 = m_acc;
        nd = 0;
        for (int t = 0; t < 300; t++) begin
            tick(1, t[0] ^ ($urandom_range(0, 3) == 0), 8'($urandom));
            nd += int'(dn[0]);
        end
        for (int t = 0; t < 40; t++) begin
            tick(1, 0, 8'h00);
            nd += int'(dn[0]);
        end
        chk("frames vs handshakes", nd, m_acc - acc0);

        for (int t = 0; t < 500; t++)
            tick($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1, 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
